// File: rtl/store_buffer.sv
// Write-behind store buffer: a small circular FIFO between the CPU store port
// and data memory. Loads can pick up pending store data by word-address match.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_we,
  input  logic [31:0]              cpu_adr,
  input  logic [31:0]              cpu_wd,
  output logic                     stall,
  input  logic [31:0]              ld_adr,
  output logic                     fwd_hit,
  output logic [31:0]              fwd_data,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [31:0]              mem_adr,
  output logic [31:0]              mem_wd,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("store_buffer: DEPTH must be a power of two >= 2");
  end

  logic [29:0]   adr_mem  [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   cnt;
  logic          enq;
  logic          deq;

  assign count     = cnt;
  assign empty     = (cnt == '0);
  assign full      = (cnt == (PW+1)'(DEPTH));
  assign stall     = cpu_we & full;
  assign mem_valid = !empty;
  assign mem_adr   = {adr_mem[head], 2'b00};
  assign mem_wd    = data_mem[head];

  // Memory handshake: the head entry transfers on any rising edge where
  // mem_valid and mem_ready are both high; while mem_ready is low the head
  // (and therefore mem_adr/mem_wd) cannot change. A full buffer refuses a
  // store even if the head drains in the same cycle.
  assign enq = cpu_we & ~full;
  assign deq = mem_valid & mem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      case ({enq, deq})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage needs no reset; occupancy is tracked by head/cnt alone.
  always_ff @(posedge clk) begin
    if (enq) begin
      adr_mem[tail]  <= cpu_adr[31:2];
      data_mem[tail] <= cpu_wd;
    end
  end

  // Walk entries oldest to newest so the youngest match overwrites older ones.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((PW+1)'(i) < cnt) && (adr_mem[head + PW'(i)] == ld_adr[31:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[head + PW'(i)];
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_we;
  logic [31:0] cpu_adr;
  logic [31:0] cpu_wd;
  logic        stall;
  logic [31:0] ld_adr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_adr;
  logic [31:0] mem_wd;
  logic [2:0]  count;
  logic        empty;
  logic        full;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_we    (cpu_we),
    .cpu_adr   (cpu_adr),
    .cpu_wd    (cpu_wd),
    .stall     (stall),
    .ld_adr    (ld_adr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_adr   (mem_adr),
    .mem_wd    (mem_wd),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // ---------------- scoreboard / model ----------------
  logic [31:0] exp_q[$];      // buffered word addresses, oldest first
  logic [31:0] exp_wd_q[$];   // matching store data
  logic [31:0] drained_q[$];  // addresses handed to memory, in order
  bit          do_deq;
  bit          do_enq;
  int          n;
  logic        f_hit;
  logic [31:0] f_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      exp_wd_q.delete();
    end else begin
      do_deq = (exp_q.size() > 0) && mem_ready;
      do_enq = cpu_we && (exp_q.size() < DEPTH);
      if (do_deq) begin
        drained_q.push_back(exp_q[0]);
        exp_q.pop_front();
        exp_wd_q.pop_front();
      end
      if (do_enq) begin
        exp_q.push_back({cpu_adr[31:2], 2'b00});
        exp_wd_q.push_back(cpu_wd);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n = exp_q.size();
      chk("count", 32'(count), 32'(n));
      chk("empty", 32'(empty), 32'(n == 0));
      chk("full", 32'(full), 32'(n == DEPTH));
      chk("stall", 32'(stall), 32'(cpu_we && n == DEPTH));
      chk("mem_valid", 32'(mem_valid), 32'(n != 0));
      if (n != 0) begin
        chk("mem_adr", mem_adr, exp_q[0]);
        chk("mem_wd", mem_wd, exp_wd_q[0]);
      end
      f_hit  = 1'b0;
      f_data = '0;
      for (int i = n - 1; i >= 0; i--) begin
        if (exp_q[i][31:2] == ld_adr[31:2]) begin
          f_hit  = 1'b1;
          f_data = exp_wd_q[i];
          break;
        end
      end
      chk("fwd_hit", 32'(fwd_hit), 32'(f_hit));
      chk("fwd_data", fwd_data, f_data);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_store(input logic we, input logic [31:0] a, input logic [31:0] d);
    cpu_we  = we;
    cpu_adr = a;
    cpu_wd  = d;
  endtask

  int cyc;
  bit accepted;

  initial begin
    reset = 1'b1; cpu_we = 1'b0; cpu_adr = '0; cpu_wd = '0;
    ld_adr = '0; mem_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_mem_valid", 32'(mem_valid), 0);
    chk("rst_fwd_hit", 32'(fwd_hit), 0);
    chk("rst_fwd_data", fwd_data, 0);
    cpu_we = 1'b1;
    #1;
    chk("rst_stall", 32'(stall), 0);
    cpu_we = 1'b0;

    // single store, held at memory, then drained
    set_store(1'b1, 32'h54, 32'h7);
    tick();
    cpu_we = 1'b0;
    #1;
    chk("single_valid", 32'(mem_valid), 1);
    chk("single_adr", mem_adr, 32'h54);
    chk("single_wd", mem_wd, 32'h7);
    chk("single_count", 32'(count), 1);
    repeat (3) begin
      tick();
      chk("hold_adr", mem_adr, 32'h54);
      chk("hold_wd", mem_wd, 32'h7);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    #1;
    chk("single_drained", 32'(empty), 1);

    // fill to full, fifth store stalls until one slot frees
    for (int i = 0; i < 5; i++) begin
      set_store(1'b1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
      if (i == 4) begin
        #1;
        chk("fill_stall", 32'(stall), 1);
        chk("fill_full", 32'(full), 1);
        chk("fill_count", 32'(count), 4);
      end
      tick();
    end
    chk("fill_refused_count", 32'(count), 4);
    chk("fill_head", mem_adr, 32'h100);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    #1;
    chk("pulse_count", 32'(count), 3);
    chk("pulse_stall", 32'(stall), 0);
    tick();
    cpu_we = 1'b0;
    ld_adr = 32'h110;
    #1;
    chk("fifth_count", 32'(count), 4);
    chk("fifth_fwd", fwd_data, 32'hA4);
    mem_ready = 1'b1;
    repeat (4) tick();
    mem_ready = 1'b0;
    #1;
    chk("fill_drained", 32'(empty), 1);

    // ten stores with mem_ready toggling; retry while stalled
    drained_q.delete();
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      set_store(1'b1, 32'(4 * i), 32'h1000 + 32'(i));
      accepted = 1'b0;
      for (int t = 0; t < 8 && !accepted; t++) begin
        mem_ready = cyc[0];
        cyc++;
        #1;
        accepted = !stall;
        tick();
      end
      chk("accept_timeout", 32'(accepted), 1);
    end
    cpu_we = 1'b0;
    mem_ready = 1'b1;
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) tick();
    mem_ready = 1'b0;
    #1;
    chk("wrap_empty", 32'(empty), 1);
    chk("wrap_drained_n", 32'(drained_q.size()), 10);
    for (int i = 0; i < 10; i++) chk("wrap_order", drained_q[i], 32'(4 * i));

    // forwarding, newest match wins; in-flight store not forwarded
    set_store(1'b1, 32'h44, 32'h1);
    ld_adr = 32'h44;
    #1;
    chk("pending_no_fwd", 32'(fwd_hit), 0);
    tick();
    set_store(1'b1, 32'h48, 32'h2);
    tick();
    set_store(1'b1, 32'h44, 32'h3);
    tick();
    cpu_we = 1'b0;
    ld_adr = 32'h46;
    #1;
    chk("fwd_newest_hit", 32'(fwd_hit), 1);
    chk("fwd_newest_data", fwd_data, 32'h3);
    ld_adr = 32'h50;
    #1;
    chk("fwd_miss_hit", 32'(fwd_hit), 0);
    chk("fwd_miss_data", fwd_data, 32'h0);
    ld_adr = 32'h48;
    #1;
    chk("fwd_mid_data", fwd_data, 32'h2);

    // simultaneous enqueue and dequeue at count 2
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    #1;
    chk("sim_pre_count", 32'(count), 2);
    chk("sim_pre_head", mem_adr, 32'h48);
    set_store(1'b1, 32'h60, 32'h6);
    mem_ready = 1'b1;
    ld_adr = 32'h48;
    #1;
    chk("deq_head_fwd_hit", 32'(fwd_hit), 1);
    chk("deq_head_fwd_data", fwd_data, 32'h2);
    tick();
    cpu_we = 1'b0;
    mem_ready = 1'b0;
    ld_adr = 32'h60;
    #1;
    chk("sim_count", 32'(count), 2);
    chk("sim_head_adr", mem_adr, 32'h44);
    chk("sim_head_wd", mem_wd, 32'h3);
    chk("sim_tail_fwd", fwd_data, 32'h6);

    // reset mid-operation discards pending stores
    set_store(1'b1, 32'h64, 32'h9);
    tick();
    cpu_we = 1'b0;
    #1;
    chk("mid_count", 32'(count), 3);
    reset = 1'b1;
    set_store(1'b1, 32'h68, 32'hA);
    mem_ready = 1'b1;
    tick();
    reset = 1'b0;
    cpu_we = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_valid", 32'(mem_valid), 0);
    repeat (3) begin
      tick();
      chk("mid_rst_no_write", 32'(mem_valid), 0);
    end
    mem_ready = 1'b0;
    tick();

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered store entries; SHALL be a power of two, >= 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cpu_we  input  1  CPU store request (the CPU's memwrite).
REQ-005 cpu_adr  input  32  CPU store byte address (dataadr); bits [1:0] SHALL be ignored (word-aligned).
REQ-006 cpu_wd  input  32  CPU store data (writedata).
REQ-007 stall  output  1  hold CPU PC/state; store not accepted this cycle.
REQ-008 ld_adr  input  32  CPU load byte address for forwarding lookup; bits [1:0] ignored.
REQ-009 fwd_hit  output  1  ld_adr word matches a buffered entry.
REQ-010 fwd_data  output  32  data of the newest matching entry; 0 when fwd_hit=0.
REQ-011 mem_valid  output  1  head entry presented to data memory.
REQ-012 mem_ready  input  1  data memory accepts head entry this cycle.
REQ-013 mem_adr  output  32  head entry word address, {stored[31:2], 2'b00}.
REQ-014 mem_wd  output  32  head entry data.
REQ-015 count  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-016 empty / full  output  1 each  count==0 / count==DEPTH.

Function
REQ-017 Storage SHALL be a circular FIFO of DEPTH entries {adr[31:2], data[31:0]} with head/tail pointers wrapping modulo DEPTH.
REQ-018 Enqueue SHALL occur at the clock edge when cpu_we=1 and full=0; entry written at tail, tail advances.
REQ-019 stall SHALL equal cpu_we & full, combinational from registered count; while full, enqueue SHALL be refused even if a dequeue occurs in the same cycle.
REQ-020 mem_valid SHALL equal !empty; mem_adr/mem_wd SHALL reflect the head entry combinationally.
REQ-021 Dequeue SHALL occur at the clock edge when mem_valid=1 and mem_ready=1; head advances.
REQ-022 While mem_valid=1 and mem_ready=0, mem_adr/mem_wd SHALL remain stable.
REQ-023 mem_ready while empty SHALL have no effect.
REQ-024 Simultaneous enqueue and dequeue SHALL leave count unchanged, both pointers advance.
REQ-025 Latency: a store accepted at edge N into an empty buffer SHALL appear on mem_valid/mem_adr/mem_wd in the cycle after edge N.
REQ-026 Entries SHALL drain in strict acceptance order; no coalescing, no reordering.
REQ-027 Forwarding SHALL compare ld_adr[31:2] against all occupied entries combinationally; on multiple matches the most recently enqueued SHALL win.
REQ-028 The head entry being dequeued in the current cycle SHALL still count as occupied for forwarding in that cycle.
REQ-029 A store being presented on cpu_we in the current cycle SHALL NOT be forwarded until it is enqueued.
REQ-030 count SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-031 At a rising edge with reset=1, head, tail and count SHALL clear to 0; entry contents are don't-care.
REQ-032 After reset: mem_valid=0, empty=1, full=0, count=0, fwd_hit=0, fwd_data=0, stall=cpu_we&0=0.
REQ-033 reset SHALL take priority over simultaneous enqueue/dequeue; pending stores are discarded, not drained.

Verification
REQ-034 Single store: reset, cpu_we=1 adr=0x54 wd=0x7 for one cycle, mem_ready=0 -> next cycle mem_valid=1 mem_adr=0x54 mem_wd=0x7 count=1; hold 3 cycles stable; mem_ready=1 -> empty next cycle.
REQ-035 Fill/stall: mem_ready=0, 5 consecutive stores (DEPTH=4) -> count=4, full=1, stall=1 on 5th; 5th not enqueued; one mem_ready pulse -> count=3, stall=0, 5th then accepted.
REQ-036 Order and wrap: 10 stores to 0x0,0x4..0x24 with mem_ready toggling every cycle -> memory side sees exactly those 10 addresses/data in order; pointers wrap twice.
REQ-037 Forwarding: store 0x44<-0x1, 0x48<-0x2, 0x44<-0x3, mem_ready=0; ld_adr=0x46 -> fwd_hit=1 fwd_data=0x3; ld_adr=0x50 -> fwd_hit=0 fwd_data=0.
REQ-038 Simultaneous: count=2, cpu_we=1 and mem_ready=1 same cycle -> count stays 2, head and tail each advance by 1.
REQ-039 Reset mid-operation: count=3, assert reset one cycle with cpu_we=1 and mem_ready=1 -> count=0, mem_valid=0, no further memory writes issued.
